// File: rtl/key_debouncer.sv
// Three-key debouncer: per-key two-flop synchronizer, debounce FSM, press pulse and level.
// Define KEY_DEBOUNCER_LONG_PRESS_EN to add per-key long-press detection on o_long_pulse.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 6000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [2:0] i_key_n,
  output logic [2:0] o_key_pulse,
  output logic [2:0] o_key_level,
  output logic [2:0] o_long_pulse
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_UP, S_DN_WAIT, S_DOWN, S_UP_WAIT} state_t;

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  // Synchronizer flops reset to the released (high) level of the active-low keys.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 3'b111;
      r_sync2 <= 3'b111;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_key
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_pulse;
    logic             r_level;
    logic             w_pulse_nxt;
    logic             w_level_nxt;
    logic             w_sync;

    assign w_sync    = ~r_sync2[k];
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_state <= S_UP;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_level <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
        r_level <= w_level_nxt;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
      w_level_nxt = r_level;
      case (r_state)
        S_UP: begin
          if (w_sync) begin
            w_state_nxt = S_DN_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        S_DN_WAIT: begin
          if (!w_sync) begin
            w_state_nxt = S_UP;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = S_DOWN;
            w_pulse_nxt = 1'b1;
            w_level_nxt = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_DOWN: begin
          if (!w_sync) begin
            w_state_nxt = S_UP_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        S_UP_WAIT: begin
          // A bounce back to pressed resumes the press silently.
          if (w_sync) begin
            w_state_nxt = S_DOWN;
          end else if (r_cnt == DB_LAST) begin
            w_state_nxt = S_UP;
            w_level_nxt = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        default: begin
          w_state_nxt = S_UP;
        end
      endcase
    end

    assign o_key_pulse[k] = r_pulse;
    assign o_key_level[k] = r_level;

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    logic [CNT_W-1:0] r_hold;
    logic             r_long;

    // Hold count survives release bounces; it passes LONG_LAST only once per press.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if (r_state == S_DOWN) begin
          if (r_hold == LONG_LAST) begin
            r_long <= 1'b1;
          end
          if (r_hold != CNT_MAX) begin
            r_hold <= r_hold + 1'b1;
          end
        end else if (r_state == S_UP) begin
          r_hold <= '0;
        end
      end
    end

    assign o_long_pulse[k] = r_long;
`else
    assign o_long_pulse[k] = 1'b0;
`endif
  end

endmodule
